instruction_queue: RTL and testbench

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue.sv | 47 ++++
 tb/tb_instruction_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// instruction_queue: circular instruction buffer feeding head opcodes to the CU and head operands onto a shared tri-state bus
module instruction_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int OPERAND_WIDTH = DATA_WIDTH / 2,
    parameter int DEPTH = 4
) (
    input  logic                                i_CLOCK,
    input  logic                                i_CLEAR,
    inout  wire  [DATA_WIDTH-1:0]               BUS,
    input  logic                                i_READ_BUS,
    input  logic                                i_WRITE_BUS,
    input  logic                                i_ADVANCE,
    input  logic                                i_FLUSH,
    output logic [DATA_WIDTH-OPERAND_WIDTH-1:0] o_OPCODE,
    output logic                                o_VALID,
    output logic                                o_FULL,
    output logic [$clog2(DEPTH):0]              o_COUNT,
    output logic                                o_OVERFLOW
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = DATA_WIDTH - OPERAND_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic pop, push;
    assign o_VALID = o_COUNT != '0;
    assign o_FULL = o_COUNT == (AW+1)'(DEPTH);
    assign pop = i_ADVANCE && o_VALID;
    assign push = i_READ_BUS && (!o_FULL || pop);
    assign o_OPCODE = o_VALID ? mem[head][DATA_WIDTH-1:OPERAND_WIDTH] : '0;
    assign BUS = (i_WRITE_BUS && o_VALID) ? {{OW{1'b0}}, mem[head][OPERAND_WIDTH-1:0]} : 'z;
    always_ff @(posedge i_CLOCK) begin
        if (i_CLEAR || i_FLUSH) begin
            head <= '0;
            tail <= '0;
            o_COUNT <= '0;
            o_OVERFLOW <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            o_COUNT <= o_COUNT + (AW+1)'(push) - (AW+1)'(pop);
            if (i_READ_BUS && !push) o_OVERFLOW <= 1'b1;
        end
    end
    always_ff @(posedge i_CLOCK) begin
        if (!i_CLEAR && !i_FLUSH && push) mem[tail] <= BUS;
    end
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed scoreboard bench for instruction_queue at default and 16/8/8 parameters
module tb_instruction_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic clr = 1'b1, rd = 1'b0, wr = 1'b0, adv = 1'b0, fl = 1'b0, ben = 1'b0;
    logic [7:0] bdrv = '0;
    wire  [7:0] bus;
    logic [3:0] opc;
    logic vld, ful, ovf;
    logic [2:0] cnt;
    assign bus = ben ? bdrv : 'z;

    logic clr2 = 1'b1, rd2 = 1'b0, wr2 = 1'b0, adv2 = 1'b0, fl2 = 1'b0, ben2 = 1'b0;
    logic [15:0] bdrv2 = '0;
    wire  [15:0] bus2;
    logic [7:0] opc2;
    logic vld2, ful2, ovf2;
    logic [3:0] cnt2;
    assign bus2 = ben2 ? bdrv2 : 'z;

    instruction_queue dut (
        .i_CLOCK(clk), .i_CLEAR(clr), .BUS(bus), .i_READ_BUS(rd), .i_WRITE_BUS(wr),
        .i_ADVANCE(adv), .i_FLUSH(fl), .o_OPCODE(opc), .o_VALID(vld), .o_FULL(ful),
        .o_COUNT(cnt), .o_OVERFLOW(ovf)
    );

    instruction_queue #(.DATA_WIDTH(16), .OPERAND_WIDTH(8), .DEPTH(8)) dut2 (
        .i_CLOCK(clk), .i_CLEAR(clr2), .BUS(bus2), .i_READ_BUS(rd2), .i_WRITE_BUS(wr2),
        .i_ADVANCE(adv2), .i_FLUSH(fl2), .o_OPCODE(opc2), .o_VALID(vld2), .o_FULL(ful2),
        .o_COUNT(cnt2), .o_OVERFLOW(ovf2)
    );

    typedef struct {
        int t;
        int id;
        logic [31:0] v;
        string nm;
    } e_t;
    e_t sb[$];
    int n_chk = 0, n_fail = 0;

    function automatic logic [31:0] obs(int id);
        case (id)
            0: obs = 32'(cnt);
            1: obs = 32'(vld);
            2: obs = 32'(ful);
            3: obs = 32'(ovf);
            4: obs = 32'(opc);
            5: obs = 32'(bus);
            10: obs = 32'(cnt2);
            11: obs = 32'(ovf2);
            12: obs = 32'(ful2);
            13: obs = 32'(opc2);
            14: obs = 32'(bus2);
            default: obs = 'x;
        endcase
    endfunction

    e_t e;
    logic [31:0] act;
    logic ok;
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].t <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.id == 6) begin
                act = 32'(bus);
                ok = (bus === 8'hzz) || (bus === 8'h00);
            end else begin
                act = obs(e.id);
                ok = act === e.v;
            end
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got %h required %h (cycle %0d)", e.nm, act, e.v, cyc);
            end
        end
    end

    task automatic ex(int id, logic [31:0] v, string nm);
        e_t x;
        x.t = cyc;
        x.id = id;
        x.v = v;
        x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(logic c, logic r, logic w, logic ad, logic f, logic [7:0] d);
        clr = c; rd = r; wr = w; adv = ad; fl = f; bdrv = d; ben = r && !w;
    endtask

    task automatic push(logic [7:0] d);
        set(0, 1, 0, 0, 0, d);
        tick();
    endtask

    task automatic set2(logic c, logic r, logic w, logic [15:0] d);
        clr2 = c; rd2 = r; wr2 = w; adv2 = 1'b0; bdrv2 = d; ben2 = r && !w;
    endtask

    logic [7:0] fill [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] wrapd [6] = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic [3:0] wrapo [6] = '{4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8};

    initial begin
        set(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        set(0, 0, 0, 0, 0, 0);
        ex(0, 0, "rst_count"); ex(1, 0, "rst_valid"); ex(2, 0, "rst_full");
        ex(3, 0, "rst_overflow"); ex(4, 0, "rst_opcode");
        tick();
        push(8'hA3);
        set(0, 0, 1, 0, 0, 0);
        ex(1, 1, "a3_valid"); ex(4, 4'hA, "a3_opcode"); ex(0, 1, "a3_count"); ex(5, 8'h03, "a3_bus");
        tick();
        set(0, 0, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) push(fill[i]);
        set(0, 0, 0, 1, 0, 0);
        ex(2, 1, "fill_full"); ex(3, 1, "fill_overflow"); ex(0, 4, "fill_count"); ex(4, 1, "fill_head");
        tick();
        for (int k = 2; k <= 4; k++) begin
            set(0, 0, 0, 1, 0, 0);
            ex(4, 32'(k), "pop_order");
            tick();
        end
        set(0, 0, 0, 0, 0, 0);
        ex(1, 0, "drain_valid"); ex(4, 0, "drain_opcode"); ex(0, 0, "drain_count");
        ex(2, 0, "drain_full"); ex(3, 1, "sticky_overflow");
        tick();
        for (int i = 0; i < 4; i++) push(fill[i]);
        set(0, 1, 0, 1, 0, 8'h66);
        ex(2, 1, "refill_full"); ex(0, 4, "refill_count"); ex(4, 1, "refill_head");
        tick();
        for (int i = 0; i < 6; i++) begin
            set(0, 1, 0, 1, 0, wrapd[i]);
            ex(0, 4, "pp_full_count"); ex(4, 32'(wrapo[i]), "pp_full_head");
            tick();
        end
        set(0, 0, 1, 1, 0, 0);
        ex(4, 9, "wrap_head9"); ex(0, 4, "wrap_count"); ex(5, 8'h09, "wrap_bus");
        tick();
        for (int k = 10; k <= 12; k++) begin
            set(0, 0, 0, 1, 0, 0);
            ex(4, 32'(k), "wrap_order");
            tick();
        end
        set(0, 1, 0, 1, 0, 8'h7E);
        ex(1, 0, "wrap_empty"); ex(0, 0, "wrap_empty_count");
        tick();
        set(0, 1, 0, 0, 0, 8'h12);
        ex(0, 1, "empty_pp_count"); ex(4, 7, "empty_pp_opcode"); ex(1, 1, "empty_pp_valid");
        tick();
        push(8'h34);
        set(0, 1, 0, 0, 1, 8'h99);
        ex(0, 3, "preflush_count"); ex(3, 1, "preflush_overflow"); ex(4, 7, "preflush_head");
        tick();
        set(0, 0, 1, 0, 0, 0);
        ex(0, 0, "flush_count"); ex(3, 0, "flush_overflow"); ex(1, 0, "flush_valid");
        ex(4, 0, "flush_opcode"); ex(6, 0, "flush_bus_z");
        tick();
        push(8'h5B);
        set(0, 1, 1, 0, 0, 0);
        ex(5, 8'h0B, "selfload_bus"); ex(0, 1, "selfload_pre");
        tick();
        set(0, 0, 0, 1, 0, 0);
        ex(0, 2, "selfload_count"); ex(4, 5, "selfload_head");
        tick();
        set(0, 0, 1, 0, 0, 0);
        ex(0, 1, "selfload_pop"); ex(4, 0, "selfload_opcode"); ex(5, 8'h0B, "selfload_operand");
        tick();
        set(1, 1, 0, 1, 0, 8'h55);
        tick();
        set(0, 0, 0, 0, 0, 0);
        ex(0, 0, "clr_push_count"); ex(1, 0, "clr_push_valid"); ex(4, 0, "clr_push_opcode");
        tick();

        set2(1, 0, 0, 0);
        tick();
        set2(0, 1, 0, 16'hBEEF);
        ex(10, 0, "w16_rst_count");
        tick();
        set2(0, 0, 1, 0);
        ex(13, 8'hBE, "w16_opcode"); ex(14, 16'h00EF, "w16_bus"); ex(10, 1, "w16_count");
        tick();
        for (int i = 1; i <= 8; i++) begin
            set2(0, 1, 0, 16'(16'h0101 * i));
            if (i == 8) begin
                ex(10, 8, "w16_full_count"); ex(11, 0, "w16_no_overflow_yet");
            end
            tick();
        end
        set2(0, 0, 0, 0);
        ex(11, 1, "w16_overflow"); ex(10, 8, "w16_count_held"); ex(12, 1, "w16_full"); ex(13, 8'hBE, "w16_head");
        tick();

        tick();
        tick();
        if (sb.size() != 0) begin
            n_fail += sb.size();
            $display("FAIL pending: got %0d unchecked entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
